// File: rtl/iir_df1_mac.sv
// ---------------------------------------------------------------------------
// iir_df1_mac
//
// Direct-form-I IIR filter built around one time-shared multiplier.
//   y[n] = (sum b_k*x[n-k] - sum a_k*y[n-k]) >>> FRAC_BITS
//
// Each accepted sample takes NB_TAPS+NA_TAPS multiply-accumulate cycles.
// The feedforward taps come first, then the feedback taps. One more cycle
// registers the result. The next sample can be accepted one cycle after that.
//
// Coefficients are written into a shadow bank at any time. The shadow bank
// is copied to the active bank when a sample is accepted, so a write never
// changes a sample that is already being filtered.
//
// Optional build macro:
//   IIR_DF1_MAC_SATURATE_EN - when defined, the shifted result clamps to the
//                             NB_OUT signed range. Otherwise it wraps.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - asynchronous, active-high reset
//   in_valid   - input sample x is offered
//   in_ready   - block accepts a sample this cycle (high only in IDLE)
//   x          - signed input sample, NB_IN bits
//   coef_we    - coefficient write strobe
//   coef_addr  - coefficient index: 0..NB_TAPS-1 = b taps,
//                NB_TAPS+k-1 = a[k]
//   coef_data  - signed coefficient value, NB_COEF bits
//   out_valid  - one-cycle pulse when y holds a new result
//   y          - signed filtered output, held until the next out_valid
// ---------------------------------------------------------------------------
module iir_df1_mac #(
    parameter int NB_IN     = 32,
    parameter int NB_OUT    = 64,
    parameter int NB_COEF   = 16,
    parameter int NB_TAPS   = 4,
    parameter int NA_TAPS   = 2,
    parameter int FRAC_BITS = 0,
    localparam int NT       = NB_TAPS + NA_TAPS,
    localparam int AW       = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [NB_IN-1:0]   x,
    input  logic                      coef_we,
    input  logic [AW-1:0]             coef_addr,
    input  logic signed [NB_COEF-1:0] coef_data,
    output logic                      out_valid,
    output logic signed [NB_OUT-1:0]  y
);

    // The accumulator has headroom for the full sum of NT products.
    localparam int ACC_W = NB_OUT + NB_COEF + 4;
    localparam int XH_N  = (NB_TAPS > 1) ? NB_TAPS - 1 : 1;
    localparam int YH_N  = (NA_TAPS > 0) ? NA_TAPS : 1;
    localparam logic [NB_COEF-1:0] COEF_ONE = NB_COEF'(1) << FRAC_BITS;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        OUT
    } state_t;

    state_t state;
    state_t state_next;

    logic [AW-1:0]             idx;
    logic                      last_tap;
    logic                      is_fb;
    logic                      accept;
    logic                      addr_ok;

    logic signed [NB_COEF-1:0] coef_shadow [0:NT-1];
    logic signed [NB_COEF-1:0] coef_act    [0:NT-1];

    logic signed [NB_IN-1:0]   x_cur;
    logic signed [NB_IN-1:0]   xh [0:XH_N-1];
    logic signed [NB_OUT-1:0]  yh [0:YH_N-1];
    logic signed [ACC_W-1:0]   acc;

    logic signed [ACC_W-1:0]   coef_op;
    logic signed [ACC_W-1:0]   samp_op;
    logic signed [ACC_W-1:0]   prod;
    logic signed [NB_OUT-1:0]  y_next;

    assign last_tap = (int'(idx) == NT - 1);
    assign is_fb    = (int'(idx) >= NB_TAPS);
    assign accept   = in_valid && in_ready;
    assign addr_ok  = (int'(coef_addr) < NT);

    // State register. Reset returns to IDLE at once, which drops any sample
    // still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the ready handshake. MAC stays in place until the
    // last tap has been accumulated.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = MAC;
                end
            end
            MAC: begin
                if (last_tap) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Shadow coefficient bank. It is writable in every state. Out-of-range
    // addresses are dropped. Reset loads a unity pass-through filter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                coef_shadow[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else if (coef_we && addr_ok) begin
            coef_shadow[coef_addr] <= coef_data;
        end
    end

    // Active coefficient bank. It is loaded only when a sample is accepted.
    // A write that lands on the accept cycle is forwarded, so that write
    // already applies to this sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NT; i++) begin
                coef_act[i] <= (i == 0) ? COEF_ONE : '0;
            end
        end else if (accept) begin
            for (int i = 0; i < NT; i++) begin
                coef_act[i] <= (coef_we && int'(coef_addr) == i) ? coef_data
                                                                  : coef_shadow[i];
            end
        end
    end

    // Operand selection for the shared multiplier. Tap index 0 uses the
    // freshly captured sample. Later b taps use the x history. The a taps
    // use the y history. Both operands are sign-extended to the accumulator
    // width.
    always_comb begin
        coef_op = '0;
        samp_op = '0;
        for (int i = 0; i < NT; i++) begin
            if (int'(idx) == i) begin
                coef_op = ACC_W'(coef_act[i]);
            end
        end
        if (int'(idx) == 0) begin
            samp_op = ACC_W'(x_cur);
        end
        for (int k = 1; k < NB_TAPS; k++) begin
            if (int'(idx) == k) begin
                samp_op = ACC_W'(xh[k-1]);
            end
        end
        for (int k = 1; k <= NA_TAPS; k++) begin
            if (int'(idx) == NB_TAPS + k - 1) begin
                samp_op = ACC_W'(yh[k-1]);
            end
        end
    end

    assign prod = coef_op * samp_op;

    // Output scaling. The accumulator is arithmetic-shifted right to drop
    // the coefficient fraction. The result is then either clamped or
    // wrapped to NB_OUT bits.
`ifdef IIR_DF1_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-NB_OUT+1){1'b0}}, {(NB_OUT-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-NB_OUT+1){1'b1}}, {(NB_OUT-1){1'b0}}};

    logic signed [ACC_W-1:0] shifted;

    assign shifted = acc >>> FRAC_BITS;

    always_comb begin
        if (shifted > SAT_MAX) begin
            y_next = SAT_MAX[NB_OUT-1:0];
        end else if (shifted < SAT_MIN) begin
            y_next = SAT_MIN[NB_OUT-1:0];
        end else begin
            y_next = shifted[NB_OUT-1:0];
        end
    end
`else
    assign y_next = NB_OUT'(acc >>> FRAC_BITS);
`endif

    // Datapath. Accept captures x and clears the accumulator. MAC adds the
    // b products and subtracts the a products. OUT publishes y and shifts
    // both histories. The histories shift only when a result completes, so
    // a reset in the middle of a sample leaves no trace of that sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_cur     <= '0;
            acc       <= '0;
            idx       <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            for (int k = 0; k < XH_N; k++) begin
                xh[k] <= '0;
            end
            for (int k = 0; k < YH_N; k++) begin
                yh[k] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_cur <= x;
                        acc   <= '0;
                        idx   <= '0;
                    end
                end
                MAC: begin
                    acc <= is_fb ? (acc - prod) : (acc + prod);
                    if (!last_tap) begin
                        idx <= idx + 1'b1;
                    end
                end
                OUT: begin
                    y         <= y_next;
                    out_valid <= 1'b1;
                    if (NB_TAPS > 1) begin
                        xh[0] <= x_cur;
                    end
                    for (int k = 1; k < XH_N; k++) begin
                        xh[k] <= xh[k-1];
                    end
                    if (NA_TAPS > 0) begin
                        yh[0] <= y_next;
                    end
                    for (int k = 1; k < YH_N; k++) begin
                        yh[k] <= yh[k-1];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/iir_df1_mac.md
IIR_DF1_MAC -- requirements
Module: iir_df1_mac

Interface
REQ-001 The block SHALL have parameter NB_IN, default 32, signed input sample width.
REQ-002 The block SHALL have parameter NB_OUT, default 64, signed output sample width.
REQ-003 The block SHALL have parameter NB_COEF, default 16, signed coefficient width.
REQ-004 The block SHALL have parameter NB_TAPS, default 4, feedforward tap count (b0..b[NB_TAPS-1]), range 1..16.
REQ-005 The block SHALL have parameter NA_TAPS, default 2, feedback tap count (a1..a[NA_TAPS]), range 0..15.
REQ-006 The block SHALL have parameter FRAC_BITS, default 0, coefficient fractional bits; the accumulator is arithmetic-shifted right by FRAC_BITS before output.
REQ-007 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-008 The block SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-009 The block SHALL have port in_valid, input, 1, sample x is offered.
REQ-010 The block SHALL have port in_ready, output, 1, block accepts a sample this cycle.
REQ-011 The block SHALL have port x, input, NB_IN, signed input sample.
REQ-012 The block SHALL have port coef_we, input, 1, coefficient write strobe.
REQ-013 The block SHALL have port coef_addr, input, $clog2(NB_TAPS+NA_TAPS), coefficient index: 0..NB_TAPS-1 = b0..b[NB_TAPS-1]; NB_TAPS+k-1 = a[k].
REQ-014 The block SHALL have port coef_data, input, NB_COEF, signed coefficient value.
REQ-015 The block SHALL have port out_valid, output, 1, one-cycle pulse, y holds a new result.
REQ-016 The block SHALL have port y, output, NB_OUT, signed filtered output, held until the next out_valid.

Function
REQ-017 The block SHALL compute y[n] = (sum b_k*x[n-k] - sum a_k*y[n-k]) >>> FRAC_BITS, signed, using one time-shared multiplier.
REQ-018 The FSM SHALL have states IDLE, MAC, OUT; in_ready = 1 only in IDLE.
REQ-019 IDLE -> MAC on in_valid && in_ready; x is captured, accumulator cleared, tap index = 0, shadow coefficients copied to the active bank.
REQ-020 MAC SHALL do one multiply-accumulate per cycle for NB_TAPS+NA_TAPS cycles (b taps first, then a taps), then go to OUT.
REQ-021 OUT SHALL register y, pulse out_valid for one cycle, shift x and y histories by one, return to IDLE.
REQ-022 Latency: out_valid SHALL assert exactly NB_TAPS+NA_TAPS+1 cycles after the accept edge; max throughput one sample per NB_TAPS+NA_TAPS+2 cycles.
REQ-023 The accumulator SHALL be NB_OUT+NB_COEF+4 bits signed; no intermediate overflow for legal parameters.
REQ-024 coef_we writes the shadow bank in any state; a write during MAC/OUT SHALL NOT affect the sample in flight; a write on the accept cycle SHALL take effect on that sample.
REQ-025 coef_addr >= NB_TAPS+NA_TAPS SHALL be ignored.
REQ-026 in_valid while not in_ready SHALL be ignored (no capture, no queueing).

Reset
REQ-027 rst SHALL immediately force: state IDLE, out_valid 0, y 0, histories 0, accumulator 0, in_ready 1 after rst deasserts.
REQ-028 Reset SHALL set both coefficient banks to b0 = 1<<FRAC_BITS, all others 0 (pass-through).
REQ-029 Reset mid-MAC SHALL abandon the sample; no out_valid follows.

Configuration
REQ-030 With macro IIR_DF1_MAC_SATURATE_EN defined, the shifted result SHALL clamp to [-2^(NB_OUT-1), 2^(NB_OUT-1)-1].
REQ-031 Without IIR_DF1_MAC_SATURATE_EN, the shifted result SHALL be truncated to its NB_OUT LSBs (two's-complement wrap).

Verification
REQ-032 Reset, default coefs, x=5 -> out_valid 7 cycles after accept, y=5.
REQ-033 Load b={1,-1,1,1}, a={0,0}; inputs 1,0,0,0,0 -> y = 1,-1,1,1,0.
REQ-034 Load b={1,0,0,0}, a1=-1, a2=0; inputs 1,1,1 -> y = 1,2,3.
REQ-035 NB_IN=NB_OUT=16, b0=2, x=32767 -> y=32767 with SATURATE_EN, y=-2 without.
REQ-036 Write b0=3 during MAC of sample x=4 -> y=4; next sample x=4 -> y=12.
REQ-037 Assert rst 3 cycles into MAC -> no out_valid, y=0, in_ready=1 after release, next x=5 gives y=5.
